// File: rtl/ph_bank_ctrl_if.sv
// Writer, reader and status signals of the PH ping-pong bank controller.
// The master side is the external logic; the slave side is ph_bank_ctrl.
interface ph_bank_ctrl_if;
   logic        frm_start;
   logic        frm_done;
   logic        wr_grant;
   logic        wr_bank;
   logic        frm_drop;
   logic [15:0] drop_cnt;
   logic        bl_req;
   logic        bl_done;
   logic        bl_grant;
   logic        bl_bank;
   logic        cpu_req;
   logic        cpu_done;
   logic        cpu_grant;
   logic        cpu_bank;
   logic [1:0]  to_err;
   logic        err_clr;

   modport master (
      output frm_start, frm_done, bl_req, bl_done, cpu_req, cpu_done, err_clr,
      input  wr_grant, wr_bank, frm_drop, drop_cnt, bl_grant, bl_bank,
             cpu_grant, cpu_bank, to_err
   );

   modport slave (
      input  frm_start, frm_done, bl_req, bl_done, cpu_req, cpu_done, err_clr,
      output wr_grant, wr_bank, frm_drop, drop_cnt, bl_grant, bl_bank,
             cpu_grant, cpu_bank, to_err
   );
endinterface

// File: rtl/ph_bank_ctrl.sv
// Ping-pong controller for the two PH cache banks: hands a free bank to the
// writer and shares completed banks between the BL processor and the CPU.
module ph_bank_ctrl #(
   parameter int unsigned TIMEOUT = 1024
) (
   input logic           clk,
   input logic           rst,
   ph_bank_ctrl_if.slave bus
);

   localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      B_FREE = 2'd0,
      B_FILL = 2'd1,
      B_FULL = 2'd2,
      B_DONE = 2'd3
   } bank_st_e;

   bank_st_e        bank_q [2];
   bank_st_e        bank_d [2];
   logic [1:0]      cpu_hold_q, cpu_hold_d;
   logic            last_done_q, last_done_d;
   logic            wr_grant_q, wr_grant_d;
   logic            wr_bank_q, wr_bank_d;
   logic            frm_drop_q, frm_drop_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic            bl_grant_q, bl_grant_d;
   logic            bl_bank_q, bl_bank_d;
   logic            cpu_grant_q, cpu_grant_d;
   logic            cpu_bank_q, cpu_bank_d;
   logic [CW-1:0]   bl_cnt_q, bl_cnt_d;
   logic [CW-1:0]   cpu_cnt_q, cpu_cnt_d;
   logic [1:0]      to_err_q, to_err_d;

   logic [1:0]      full_v;
   logic [1:0]      avail_v;
   logic            bl_to, bl_rel;
   logic            cpu_to, cpu_rel;

   assign full_v[0]  = (bank_q[0] == B_FULL);
   assign full_v[1]  = (bank_q[1] == B_FULL);
   assign avail_v[0] = (bank_q[0] == B_FULL) || (bank_q[0] == B_DONE);
   assign avail_v[1] = (bank_q[1] == B_FULL) || (bank_q[1] == B_DONE);

   // A real done in the expiry cycle counts as a normal release, not a timeout.
   assign bl_to   = bl_grant_q && !bus.bl_done && (bl_cnt_q == TO_VAL);
   assign bl_rel  = bl_grant_q && (bus.bl_done || (bl_cnt_q == TO_VAL));
   assign cpu_to  = cpu_grant_q && !bus.cpu_done && (cpu_cnt_q == TO_VAL);
   assign cpu_rel = cpu_grant_q && (bus.cpu_done || (cpu_cnt_q == TO_VAL));

   // NOTE: every target gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      bank_d      = bank_q;
      cpu_hold_d  = cpu_hold_q;
      last_done_d = last_done_q;
      wr_grant_d  = wr_grant_q;
      wr_bank_d   = wr_bank_q;
      frm_drop_d  = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      bl_grant_d  = bl_grant_q;
      bl_bank_d   = bl_bank_q;
      cpu_grant_d = cpu_grant_q;
      cpu_bank_d  = cpu_bank_q;
      bl_cnt_d    = bl_cnt_q;
      cpu_cnt_d   = cpu_cnt_q;

      if (bus.frm_start && !wr_grant_q) begin
         if (bank_q[0] == B_FREE) begin
            bank_d[0]  = B_FILL;
            wr_grant_d = 1'b1;
            wr_bank_d  = 1'b0;
         end else if (bank_q[1] == B_FREE) begin
            bank_d[1]  = B_FILL;
            wr_grant_d = 1'b1;
            wr_bank_d  = 1'b1;
         end else begin
            frm_drop_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end
      if (bus.frm_done && wr_grant_q) begin
         bank_d[wr_bank_q] = B_FULL;
         last_done_d       = wr_bank_q;
         wr_grant_d        = 1'b0;
      end

      if (bl_grant_q) begin
         bl_cnt_d = bl_cnt_q + CW'(1);
         if (bl_rel) begin
            bl_grant_d = 1'b0;
            if (bank_q[bl_bank_q] == B_FULL) bank_d[bl_bank_q] = B_DONE;
         end
      end else if (bus.bl_req && (full_v != 2'b00)) begin
         bl_grant_d = 1'b1;
         bl_cnt_d   = CW'(1);
         if (full_v == 2'b11) bl_bank_d = ~last_done_q;
         else                 bl_bank_d = full_v[1];
      end

      if (cpu_grant_q) begin
         cpu_cnt_d = cpu_cnt_q + CW'(1);
         if (cpu_rel) begin
            cpu_grant_d            = 1'b0;
            cpu_hold_d[cpu_bank_q] = 1'b0;
         end
      end else if (bus.cpu_req && (avail_v != 2'b00)) begin
         cpu_grant_d = 1'b1;
         cpu_cnt_d   = CW'(1);
         cpu_bank_d  = avail_v[last_done_q] ? last_done_q : ~last_done_q;
         cpu_hold_d[cpu_bank_d] = 1'b1;
      end

      // A DONE bank being granted to the CPU this cycle must not be freed under it.
      for (int b = 0; b < 2; b++) begin
         if (bank_q[b] == B_DONE && !cpu_hold_q[b] && !cpu_hold_d[b]) bank_d[b] = B_FREE;
      end

      to_err_d = bus.err_clr ? 2'b00 : to_err_q;
      if (bl_to)  to_err_d[0] = 1'b1;
      if (cpu_to) to_err_d[1] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_q[0]   <= B_FREE;
         bank_q[1]   <= B_FREE;
         cpu_hold_q  <= 2'b00;
         last_done_q <= 1'b0;
         wr_grant_q  <= 1'b0;
         wr_bank_q   <= 1'b0;
         frm_drop_q  <= 1'b0;
         drop_cnt_q  <= 16'd0;
         bl_grant_q  <= 1'b0;
         bl_bank_q   <= 1'b0;
         cpu_grant_q <= 1'b0;
         cpu_bank_q  <= 1'b0;
         bl_cnt_q    <= '0;
         cpu_cnt_q   <= '0;
         to_err_q    <= 2'b00;
      end else begin
         bank_q      <= bank_d;
         cpu_hold_q  <= cpu_hold_d;
         last_done_q <= last_done_d;
         wr_grant_q  <= wr_grant_d;
         wr_bank_q   <= wr_bank_d;
         frm_drop_q  <= frm_drop_d;
         drop_cnt_q  <= drop_cnt_d;
         bl_grant_q  <= bl_grant_d;
         bl_bank_q   <= bl_bank_d;
         cpu_grant_q <= cpu_grant_d;
         cpu_bank_q  <= cpu_bank_d;
         bl_cnt_q    <= bl_cnt_d;
         cpu_cnt_q   <= cpu_cnt_d;
         to_err_q    <= to_err_d;
      end
   end

   always_comb begin
      bus.wr_grant  = wr_grant_q;
      bus.wr_bank   = wr_bank_q;
      bus.frm_drop  = frm_drop_q;
      bus.drop_cnt  = drop_cnt_q;
      bus.bl_grant  = bl_grant_q;
      bus.bl_bank   = bl_bank_q;
      bus.cpu_grant = cpu_grant_q;
      bus.cpu_bank  = cpu_bank_q;
      bus.to_err    = to_err_q;
   end

endmodule

// File: doc/ph_bank_ctrl.md
# ph_bank_ctrl

Ping-pong bank controller for the two PH cache BRAM banks. It tells the PH writer which bank to fill and shares completed banks between two readers: the baseline processor (BL) and the CPU/AXI reader. A bank is never rewritten while a reader holds it. Frames that arrive with no free bank are dropped and counted. The block sits between the MAROC stream front end, the cache BRAMs, PH_BL and the MicroBlaze register interface.

## Interface
Parameters:
- TIMEOUT, 1024: maximum cycles a reader may hold a bank before forced release (≥2).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- frm_start  in  1  writer pulse: new frame begins.
- frm_done  in  1  writer pulse: frame fully written.
- wr_grant  out  1  writer may write `wr_bank`.
- wr_bank  out  1  bank index for the writer.
- frm_drop  out  1  1-cycle pulse: frame rejected, no free bank.
- drop_cnt  out  16  rejected frames, saturating.
- bl_req / cpu_req  in  1  level read requests.
- bl_done / cpu_done  in  1  release pulses.
- bl_grant / cpu_grant  out  1  read grant, level.
- bl_bank / cpu_bank  out  1  granted bank index (also drives the BL data mux).
- to_err  out  2  sticky timeout flags, [0]=BL, [1]=CPU.
- err_clr  in  1  clears `to_err`.

## Operation
- Each bank holds one state: FREE, FILL, FULL (not yet consumed by BL) or DONE (consumed by BL).
- `cpu_hold[b]` marks a bank held by the CPU. `last_done` records the bank of the most recent frm_done.

Writer:
- frm_start with wr_grant=0 takes a FREE bank (bank 0 if both are FREE) into FILL, sets wr_bank and asserts wr_grant.
- If no bank is FREE: pulse frm_drop, increment drop_cnt (saturates at 0xFFFF), keep wr_grant=0.
- frm_start while wr_grant=1 is ignored.
- frm_done with wr_grant=1: FILL→FULL, last_done←bank, wr_grant drops. frm_done with wr_grant=0 is ignored.

BL reader:
- While bl_grant=0 and bl_req=1, grant the oldest FULL bank.
- If both banks are FULL, the oldest is the bank ≠ last_done.
- bl_done: the bank goes FULL→DONE and bl_grant drops.

CPU reader:
- While cpu_grant=0 and cpu_req=1, grant the newest bank in FULL or DONE and set its cpu_hold.
- The newest bank is last_done if that bank is FULL/DONE, otherwise the other bank.
- cpu_done clears cpu_hold and drops cpu_grant.
- BL and CPU may hold the same bank at the same time.

Freeing:
- A DONE bank with cpu_hold=0 returns to FREE on the next cycle.

Timeout:
- Each reader has a counter that starts at grant.
- If the counter reaches TIMEOUT with no done, the block forces the equivalent of done for that reader and sets its to_err bit.
- to_err is cleared by err_clr. If a timeout and err_clr occur in the same cycle, set wins.

## Timing
- All outputs are registered. Reset values: grants 0, banks 0, all banks FREE, last_done=0, drop_cnt=0, to_err=0, frm_drop=0.
- Grant latency: a qualifying req/frm_start in cycle N gives grant=1 and a valid bank index in cycle N+1.
- Release: done in cycle N gives grant=0 in cycle N+1. The bank state update is visible in N+1, and DONE→FREE is visible in N+2.
- Grant is low for at least 1 cycle between grants. A req held high re-arbitrates from N+1.
- Decisions in a cycle use the state registered at the start of that cycle. Same-cycle releases do not free a bank for a same-cycle request.
- Simultaneous bl_req and cpu_req both grant in the same cycle.
- Simultaneous frm_done and bl_req: BL sees the bank as FULL one cycle later.
- done while the matching grant=0 is ignored.
- Reset asserted mid-operation clears everything immediately; outputs stay at reset values until rst returns high.

## Test plan
- Single frame, writer only: frm_start, then frm_done → wr_grant=1, wr_bank=0; bank0 FULL; second frame → wr_bank=1.
- BL consumes: two frames filled (last_done=1), bl_req → bl_bank=0 first; after bl_done, next grant gives bl_bank=1; both banks FREE 2 cycles after the final bl_done.
- Overflow: both banks FULL, frm_start ×3 → three frm_drop pulses, drop_cnt=3, wr_grant stays 0. Separately, preload drop_cnt at 0xFFFF → it stays 0xFFFF.
- Shared hold: bank0 FULL; cpu_req and bl_req in the same cycle → both grant bank0; bl_done → bank0 DONE but not FREE; frm_start → wr_bank=1; cpu_done → bank0 FREE 2 cycles later.
- Timeout: BL granted, no bl_done for TIMEOUT cycles → bl_grant falls at cycle TIMEOUT+1, to_err=2'b01, bank DONE; err_clr → to_err=0.
- Async reset: assert rst mid-FILL, between clock edges → all outputs at reset values immediately; after release, frm_start gives wr_bank=0.
